// File: rtl/lsu_ctrl_pkg.sv
// Shared DTCM widths, access-size codes and LSU FSM state encoding.
package lsu_ctrl_pkg;

    localparam int unsigned DTCM_ADDR_WIDTH = 16;
    localparam int unsigned DTCM_RAM_DW     = 32;
    localparam int unsigned DTCM_RAM_MW     = 4;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'd0,
        LSU_SIZE_H = 2'd1,
        LSU_SIZE_W = 2'd2,
        LSU_SIZE_X = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_ST_IDLE = 2'd0,
        LSU_ST_CMD  = 2'd1,
        LSU_ST_RSP  = 2'd2,
        LSU_ST_WB   = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational store lane alignment, misalign detection and load extraction/extension.
module lsu_align
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned MW = 4
) (
    input  logic [1:0]    st_addr_i,
    input  lsu_size_e     st_size_i,
    input  logic [DW-1:0] st_wdata_i,
    output logic [MW-1:0] st_wmask_o,
    output logic [DW-1:0] st_wdata_o,
    output logic          st_err_o,
    input  logic [1:0]    ld_addr_i,
    input  lsu_size_e     ld_size_i,
    input  logic          ld_unsigned_i,
    input  logic [DW-1:0] ld_rdata_i,
    output logic [DW-1:0] ld_data_o
);

    logic [DW-1:0] ld_shifted;
    logic          ld_sx;

    always_comb begin
        st_wmask_o = '0;
        st_wdata_o = '0;
        st_err_o   = 1'b0;
        case (st_size_i)
            LSU_SIZE_B: begin
                st_wmask_o = MW'(1) << st_addr_i;
                st_wdata_o = {(DW/8){st_wdata_i[7:0]}};
            end
            LSU_SIZE_H: begin
                st_wmask_o = MW'(3) << {st_addr_i[1], 1'b0};
                st_wdata_o = {(DW/16){st_wdata_i[15:0]}};
                st_err_o   = st_addr_i[0];
            end
            LSU_SIZE_W: begin
                st_wmask_o = '1;
                st_wdata_o = st_wdata_i;
                st_err_o   = |st_addr_i;
            end
            default: st_err_o = 1'b1;
        endcase
    end

    always_comb begin
        ld_shifted = ld_rdata_i >> {ld_addr_i, 3'b000};
        ld_sx      = ~ld_unsigned_i;
        ld_data_o  = ld_rdata_i;
        case (ld_size_i)
            LSU_SIZE_B: ld_data_o = {{(DW-8){ld_sx & ld_shifted[7]}}, ld_shifted[7:0]};
            LSU_SIZE_H: ld_data_o = {{(DW-16){ld_sx & ld_shifted[15]}}, ld_shifted[15:0]};
            default:    ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller between the EXU, the DTCM bus and write-back.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned AW = DTCM_ADDR_WIDTH,
    parameter int unsigned DW = DTCM_RAM_DW,
    parameter int unsigned MW = DTCM_RAM_MW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          exu2lsu_req_valid,
    output logic          exu2lsu_req_ready,
    input  logic          exu2lsu_req_read,
    input  logic [1:0]    exu2lsu_req_size,
    input  logic          exu2lsu_req_unsigned,
    input  logic [AW-1:0] exu2lsu_req_addr,
    input  logic [DW-1:0] exu2lsu_req_wdata,
    input  logic [4:0]    exu2lsu_req_rd,
    output logic          lsu2wb_valid,
    input  logic          lsu2wb_ready,
    output logic          lsu2wb_we,
    output logic [4:0]    lsu2wb_rd,
    output logic [DW-1:0] lsu2wb_rdata,
    output logic          lsu2wb_err,
    output logic          lsu2dtcm_cmd_valid,
    input  logic          lsu2dtcm_cmd_ready,
    output logic          lsu2dtcm_cmd_read,
    output logic [AW-1:0] lsu2dtcm_cmd_addr,
    output logic [DW-1:0] lsu2dtcm_cmd_wdata,
    output logic [MW-1:0] lsu2dtcm_cmd_wmask,
    input  logic          lsu2dtcm_rsp_valid,
    output logic          lsu2dtcm_rsp_ready,
    input  logic [DW-1:0] lsu2dtcm_rsp_rdata
);

    lsu_state_e    state_q, state_d;
    logic [AW-1:0] addr_q;
    lsu_size_e     size_q;
    logic          uns_q;
    logic          read_q;
    logic [4:0]    rd_q;
    logic [DW-1:0] wdata_q;
    logic [MW-1:0] wmask_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;

    logic [MW-1:0] al_wmask;
    logic [DW-1:0] al_wdata;
    logic          al_err;
    logic [DW-1:0] al_ldata;
    logic          req_hs;
    logic          rsp_hs;

    lsu_align #(.DW(DW), .MW(MW)) u_align (
        .st_addr_i     (exu2lsu_req_addr[1:0]),
        .st_size_i     (lsu_size_e'(exu2lsu_req_size)),
        .st_wdata_i    (exu2lsu_req_wdata),
        .st_wmask_o    (al_wmask),
        .st_wdata_o    (al_wdata),
        .st_err_o      (al_err),
        .ld_addr_i     (addr_q[1:0]),
        .ld_size_i     (size_q),
        .ld_unsigned_i (uns_q),
        .ld_rdata_i    (lsu2dtcm_rsp_rdata),
        .ld_data_o     (al_ldata)
    );

    assign req_hs = exu2lsu_req_valid & exu2lsu_req_ready;
    assign rsp_hs = lsu2dtcm_rsp_valid & lsu2dtcm_rsp_ready;

    always_comb begin
        state_d            = state_q;
        exu2lsu_req_ready  = 1'b0;
        lsu2dtcm_cmd_valid = 1'b0;
        lsu2dtcm_rsp_ready = 1'b0;
        lsu2wb_valid       = 1'b0;
        case (state_q)
            LSU_ST_IDLE: begin
                exu2lsu_req_ready = 1'b1;
                if (exu2lsu_req_valid) state_d = al_err ? LSU_ST_WB : LSU_ST_CMD;
            end
            LSU_ST_CMD: begin
                lsu2dtcm_cmd_valid = 1'b1;
                if (lsu2dtcm_cmd_ready) state_d = LSU_ST_RSP;
            end
            LSU_ST_RSP: begin
                lsu2dtcm_rsp_ready = 1'b1;
                if (lsu2dtcm_rsp_valid) state_d = LSU_ST_WB;
            end
            default: begin
                lsu2wb_valid = 1'b1;
                if (lsu2wb_ready) state_d = LSU_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LSU_ST_IDLE;
        else        state_q <= state_d;
    end

    // Loads and faulting accesses carry an all-zero mask/data so the payload never enables a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            size_q  <= LSU_SIZE_B;
            uns_q   <= 1'b0;
            read_q  <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (req_hs) begin
                addr_q  <= exu2lsu_req_addr;
                size_q  <= lsu_size_e'(exu2lsu_req_size);
                uns_q   <= exu2lsu_req_unsigned;
                read_q  <= exu2lsu_req_read;
                rd_q    <= exu2lsu_req_rd;
                err_q   <= al_err;
                wmask_q <= (exu2lsu_req_read || al_err) ? '0 : al_wmask;
                wdata_q <= (exu2lsu_req_read || al_err) ? '0 : al_wdata;
                rdata_q <= '0;
            end
            if (rsp_hs) rdata_q <= read_q ? al_ldata : '0;
        end
    end

    assign lsu2dtcm_cmd_read  = read_q;
    assign lsu2dtcm_cmd_addr  = {addr_q[AW-1:2], 2'b00};
    assign lsu2dtcm_cmd_wdata = wdata_q;
    assign lsu2dtcm_cmd_wmask = wmask_q;
    assign lsu2wb_we          = read_q & ~err_q;
    assign lsu2wb_rd          = rd_q;
    assign lsu2wb_rdata       = rdata_q;
    assign lsu2wb_err         = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: the bench plays both the EXU and a DTCM responder.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_read, req_uns;
    logic [1:0]  req_size;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        wb_valid, wb_ready, wb_we, wb_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_rdata;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.AW(16), .DW(32), .MW(4)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .exu2lsu_req_valid    (req_valid),
        .exu2lsu_req_ready    (req_ready),
        .exu2lsu_req_read     (req_read),
        .exu2lsu_req_size     (req_size),
        .exu2lsu_req_unsigned (req_uns),
        .exu2lsu_req_addr     (req_addr),
        .exu2lsu_req_wdata    (req_wdata),
        .exu2lsu_req_rd       (req_rd),
        .lsu2wb_valid         (wb_valid),
        .lsu2wb_ready         (wb_ready),
        .lsu2wb_we            (wb_we),
        .lsu2wb_rd            (wb_rd),
        .lsu2wb_rdata         (wb_rdata),
        .lsu2wb_err           (wb_err),
        .lsu2dtcm_cmd_valid   (cmd_valid),
        .lsu2dtcm_cmd_ready   (cmd_ready),
        .lsu2dtcm_cmd_read    (cmd_read),
        .lsu2dtcm_cmd_addr    (cmd_addr),
        .lsu2dtcm_cmd_wdata   (cmd_wdata),
        .lsu2dtcm_cmd_wmask   (cmd_wmask),
        .lsu2dtcm_rsp_valid   (rsp_valid),
        .lsu2dtcm_rsp_ready   (rsp_ready),
        .lsu2dtcm_rsp_rdata   (rsp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request for a single cycle; returns at cycle 1 after the handshake.
    task automatic issue(input logic rd_n, input logic [1:0] sz, input logic uns,
                         input logic [15:0] a, input logic [31:0] wd, input logic [4:0] rd);
        req_valid = 1'b1; req_read = rd_n; req_size = sz; req_uns = uns;
        req_addr = a; req_wdata = wd; req_rd = rd;
        chk("req_ready_c0", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    // From cycle 1 (CMD, cmd_ready=1): handshake, answer in RSP, land at cycle 3 (WB).
    task automatic finish_cmd(input logic [31:0] data);
        step();
        rsp_valid = 1'b1; rsp_rdata = data;
        step();
        rsp_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_size = 2'd0; req_uns = 1'b0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        wb_ready = 1'b1; cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_rdata = '0;

        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_rsp_ready", 32'(rsp_ready), 32'd0);
        chk("rst_wb_valid",  32'(wb_valid),  32'd0);
        chk("rst_wb_we",     32'(wb_we),     32'd0);
        chk("rst_wmask",     32'(cmd_wmask), 32'd0);
        chk("rst_cmd_addr",  32'(cmd_addr),  32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Store byte 0xA5 to 0x0103
        issue(1'b0, 2'd0, 1'b0, 16'h0103, 32'h123456A5, 5'd5);
        chk("sb_cmd_valid", 32'(cmd_valid), 32'd1);
        chk("sb_cmd_read",  32'(cmd_read),  32'd0);
        chk("sb_cmd_addr",  32'(cmd_addr),  32'h0100);
        chk("sb_wmask",     32'(cmd_wmask), 32'b1000);
        chk("sb_wdata",     cmd_wdata,      32'hA5A5A5A5);
        chk("sb_req_ready", 32'(req_ready), 32'd0);
        step();
        chk("sb_rsp_ready", 32'(rsp_ready), 32'd1);
        chk("sb_cmd_drop",  32'(cmd_valid), 32'd0);
        rsp_valid = 1'b1; rsp_rdata = 32'hDEADBEEF;
        step();
        rsp_valid = 1'b0;
        chk("sb_wb_valid", 32'(wb_valid), 32'd1);
        chk("sb_wb_we",    32'(wb_we),    32'd0);
        chk("sb_wb_err",   32'(wb_err),   32'd0);
        chk("sb_wb_rdata", wb_rdata,      32'd0);
        chk("sb_wb_rd",    32'(wb_rd),    32'd5);
        step();
        chk("sb_idle", 32'(req_ready), 32'd1);

        // Load half signed / unsigned from 0x0102
        issue(1'b1, 2'd1, 1'b0, 16'h0102, 32'hFFFFFFFF, 5'd7);
        chk("lh_cmd_read", 32'(cmd_read),  32'd1);
        chk("lh_wmask",    32'(cmd_wmask), 32'd0);
        chk("lh_cmd_addr", 32'(cmd_addr),  32'h0100);
        finish_cmd(32'h80011234);
        chk("lh_rdata", wb_rdata,   32'hFFFF8001);
        chk("lh_we",    32'(wb_we), 32'd1);
        chk("lh_rd",    32'(wb_rd), 32'd7);
        step();
        issue(1'b1, 2'd1, 1'b1, 16'h0102, 32'h0, 5'd7);
        finish_cmd(32'h80011234);
        chk("lhu_rdata", wb_rdata, 32'h00008001);
        step();

        // Load byte signed from 0x0101, store half / word
        issue(1'b1, 2'd0, 1'b0, 16'h0101, 32'h0, 5'd3);
        finish_cmd(32'h00008000);
        chk("lb_rdata", wb_rdata, 32'hFFFFFF80);
        step();
        issue(1'b0, 2'd1, 1'b0, 16'h0102, 32'h0000BEEF, 5'd1);
        chk("sh_wmask", 32'(cmd_wmask), 32'b1100);
        chk("sh_wdata", cmd_wdata,      32'hBEEFBEEF);
        finish_cmd(32'h0);
        step();
        issue(1'b0, 2'd2, 1'b0, 16'h0104, 32'h11223344, 5'd1);
        chk("sw_wmask", 32'(cmd_wmask), 32'hF);
        chk("sw_wdata", cmd_wdata,      32'h11223344);
        chk("sw_addr",  32'(cmd_addr),  32'h0104);
        finish_cmd(32'h0);
        step();

        // Error paths: misaligned word, size 3, misaligned half
        issue(1'b1, 2'd2, 1'b0, 16'h0101, 32'h0, 5'd4);
        chk("ew_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("ew_wb_valid",  32'(wb_valid),  32'd1);
        chk("ew_err",       32'(wb_err),    32'd1);
        chk("ew_we",        32'(wb_we),     32'd0);
        chk("ew_rdata",     wb_rdata,       32'd0);
        step();
        chk("ew_idle", 32'(req_ready), 32'd1);
        issue(1'b1, 2'd3, 1'b0, 16'h0100, 32'h0, 5'd4);
        chk("ex_err",       32'(wb_err),    32'd1);
        chk("ex_cmd_valid", 32'(cmd_valid), 32'd0);
        step();
        issue(1'b0, 2'd1, 1'b0, 16'h0103, 32'h0, 5'd4);
        chk("eh_err",   32'(wb_err),    32'd1);
        chk("eh_wmask", 32'(cmd_wmask), 32'd0);
        step();

        // cmd_ready low for 3 cycles: wb_valid at cycle 6
        cmd_ready = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 16'h0108, 32'hCAFEF00D, 5'd2);
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) cmd_ready = 1'b1;
            chk("st_cmd_valid", 32'(cmd_valid), 32'd1);
            chk("st_cmd_addr",  32'(cmd_addr),  32'h0108);
            chk("st_cmd_wdata", cmd_wdata,      32'hCAFEF00D);
            chk("st_cmd_wmask", 32'(cmd_wmask), 32'hF);
            step();
        end
        chk("st_c5_rsp_ready", 32'(rsp_ready), 32'd1);
        chk("st_c5_wb_valid",  32'(wb_valid),  32'd0);
        rsp_valid = 1'b1;
        step();
        rsp_valid = 1'b0;
        chk("st_c6_wb_valid", 32'(wb_valid), 32'd1);
        step();

        // Reset while in RSP, then a stray response
        issue(1'b1, 2'd2, 1'b0, 16'h0110, 32'h0, 5'd6);
        step();
        chk("rr_rsp_ready", 32'(rsp_ready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rr_rsp_ready0", 32'(rsp_ready), 32'd0);
        chk("rr_wb_valid",  32'(wb_valid),  32'd0);
        chk("rr_req_ready", 32'(req_ready), 32'd1);
        step();
        rst_n = 1'b1;
        rsp_valid = 1'b1; rsp_rdata = 32'h55555555;
        chk("rr_stray_rsp_ready", 32'(rsp_ready), 32'd0);
        step();
        rsp_valid = 1'b0;
        chk("rr_stray_wb", 32'(wb_valid), 32'd0);
        chk("rr_idle",     32'(req_ready), 32'd1);
        step();
        chk("rr_stray_wb2", 32'(wb_valid), 32'd0);

        // wb_ready low for 2 cycles with a new request waiting
        issue(1'b1, 2'd0, 1'b1, 16'h0100, 32'h0, 5'd9);
        step();
        wb_ready = 1'b0;
        rsp_valid = 1'b1; rsp_rdata = 32'h000000FF;
        step();
        rsp_valid = 1'b0;
        req_valid = 1'b1; req_read = 1'b0; req_size = 2'd0; req_uns = 1'b0;
        req_addr = 16'h0201; req_wdata = 32'h0000003C; req_rd = 5'd0;
        for (int c = 3; c <= 5; c++) begin
            if (c == 5) wb_ready = 1'b1;
            chk("wbs_valid",     32'(wb_valid),  32'd1);
            chk("wbs_rdata",     wb_rdata,       32'h000000FF);
            chk("wbs_rd",        32'(wb_rd),     32'd9);
            chk("wbs_we",        32'(wb_we),     32'd1);
            chk("wbs_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        chk("wbs_c6_req_ready", 32'(req_ready), 32'd1);
        chk("wbs_c6_wb_valid",  32'(wb_valid),  32'd0);
        step();
        req_valid = 1'b0;
        chk("wbs_c7_cmd_valid", 32'(cmd_valid), 32'd1);
        chk("wbs_c7_cmd_addr",  32'(cmd_addr),  32'h0200);
        chk("wbs_c7_wmask",     32'(cmd_wmask), 32'b0010);
        chk("wbs_c7_wdata",     cmd_wdata,      32'h3C3C3C3C);
        finish_cmd(32'h0);
        chk("wbs_tail_wb", 32'(wb_valid), 32'd1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
